// File: rtl/arm_pkg.sv
// Shared ARM decode definitions: instruction field positions, mode/opcode/condition
// encodings, execute-command codes and the ID/EXE pipeline record.
package arm_pkg;

    localparam int unsigned COND_LSB   = 28;
    localparam int unsigned MODE_LSB   = 26;
    localparam int unsigned I_BIT      = 25;
    localparam int unsigned OPCODE_LSB = 21;
    localparam int unsigned S_BIT      = 20;
    localparam int unsigned RN_LSB     = 16;
    localparam int unsigned RD_LSB     = 12;
    localparam int unsigned RM_LSB     = 0;

    localparam int unsigned NUM_REGS   = 15;
    localparam logic [3:0]  PC_INDEX   = 4'hF;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MEM = 4'b0010;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       branch;
        logic       status_update;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm24;
        logic [3:0]  dest;
        ctrl_t       ctrl;
    } idexe_t;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        {n, z, c, v} = nzcv;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/register_file.sv
// 15x32 register file: two asynchronous read ports with write-through bypass,
// one synchronous write port, synchronous reset; index 15 reads back the PC.
module register_file
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_rd_addr1,
    input  logic [3:0]  i_rd_addr2,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data1,
    output logic [31:0] o_rd_data2
);

    logic [31:0] r_regs [NUM_REGS];
    logic        w_wr_valid;

    assign w_wr_valid = i_wr_en && (i_wr_addr != PC_INDEX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data1 = '0;
        if (i_rd_addr1 == PC_INDEX)
            o_rd_data1 = i_pc;
        else if (w_wr_valid && (i_wr_addr == i_rd_addr1))
            o_rd_data1 = i_wr_data;
        else
            o_rd_data1 = r_regs[i_rd_addr1];
    end

    always_comb begin
        o_rd_data2 = '0;
        if (i_rd_addr2 == PC_INDEX)
            o_rd_data2 = i_pc;
        else if (w_wr_valid && (i_wr_addr == i_rd_addr2))
            o_rd_data2 = i_wr_data;
        else
            o_rd_data2 = r_regs[i_rd_addr2];
    end

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage: decode, condition check, register read, RAW hazard
// detection against EXE/MEM, and the ID/EXE pipeline register.
module id_stage
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze,
    input  logic [31:0] pcIn,
    input  logic [31:0] instruction,
    input  logic [3:0]  statusReg,
    input  logic        wbEn,
    input  logic [3:0]  wbDest,
    input  logic [31:0] wbValue,
    input  logic        exeWbEn,
    input  logic [3:0]  exeDest,
    input  logic        memWbEn,
    input  logic [3:0]  memDest,
    output logic        hazard,
    output logic [31:0] pcOut,
    output logic [31:0] valRn,
    output logic [31:0] valRm,
    output logic        imm,
    output logic [11:0] shiftOperand,
    output logic [23:0] signedImm24,
    output logic [3:0]  dest,
    output logic [3:0]  exeCmd,
    output logic        memRead,
    output logic        memWrite,
    output logic        wbEnOut,
    output logic        branch,
    output logic        statusUpdate
);

    mode_e       w_mode;
    logic [3:0]  w_opcode, w_rn, w_rd, w_rm, w_src2;
    logic        w_i, w_s;
    logic        w_is_dp, w_is_str, w_is_ldr, w_is_mov;
    logic        w_src1_used, w_two_src, w_exe_hz, w_mem_hz;
    logic        w_dp_defined;
    logic [3:0]  w_dp_cmd;
    logic [31:0] w_val_rn, w_val_rm;
    ctrl_t       w_dec, w_ctrl;
    idexe_t      w_next, r_idexe;

    assign w_mode   = mode_e'(instruction[MODE_LSB +: 2]);
    assign w_opcode = instruction[OPCODE_LSB +: 4];
    assign w_i      = instruction[I_BIT];
    assign w_s      = instruction[S_BIT];
    assign w_rn     = instruction[RN_LSB +: 4];
    assign w_rd     = instruction[RD_LSB +: 4];
    assign w_rm     = instruction[RM_LSB +: 4];

    assign w_is_dp  = (w_mode == MODE_DP);
    assign w_is_ldr = (w_mode == MODE_MEM) && w_s;
    assign w_is_str = (w_mode == MODE_MEM) && !w_s;
    assign w_is_mov = w_is_dp && ((w_opcode == OP_MOV) || (w_opcode == OP_MVN));

    // STR reads its store data from Rd through the second port.
    assign w_src2      = w_is_str ? w_rd : w_rm;
    assign w_src1_used = (w_mode != MODE_BR) && !w_is_mov;
    assign w_two_src   = (w_is_dp && !w_i) || w_is_str;

    assign w_exe_hz = exeWbEn && ((w_src1_used && (exeDest == w_rn)) ||
                                  (w_two_src   && (exeDest == w_src2)));
    assign w_mem_hz = memWbEn && ((w_src1_used && (memDest == w_rn)) ||
                                  (w_two_src   && (memDest == w_src2)));
    assign hazard   = !flush && (w_exe_hz || w_mem_hz);

    always_comb begin
        w_dp_defined = 1'b1;
        w_dp_cmd     = '0;
        case (w_opcode)
            OP_MOV:         w_dp_cmd = EXE_MOV;
            OP_MVN:         w_dp_cmd = EXE_MVN;
            OP_ADD:         w_dp_cmd = EXE_ADD;
            OP_ADC:         w_dp_cmd = EXE_ADC;
            OP_SUB, OP_CMP: w_dp_cmd = EXE_SUB;
            OP_SBC:         w_dp_cmd = EXE_SBC;
            OP_AND, OP_TST: w_dp_cmd = EXE_AND;
            OP_ORR:         w_dp_cmd = EXE_ORR;
            OP_EOR:         w_dp_cmd = EXE_EOR;
            default:        w_dp_defined = 1'b0;
        endcase
    end

    always_comb begin
        w_dec = '0;
        case (w_mode)
            MODE_DP: begin
                if (w_dp_defined) begin
                    w_dec.exe_cmd       = w_dp_cmd;
                    w_dec.wb_en         = (w_opcode != OP_CMP) && (w_opcode != OP_TST);
                    w_dec.status_update = w_s;
                end
            end
            MODE_MEM: begin
                w_dec.exe_cmd   = EXE_MEM;
                w_dec.mem_read  = w_is_ldr;
                w_dec.mem_write = w_is_str;
                w_dec.wb_en     = w_is_ldr;
            end
            MODE_BR:  w_dec.branch = 1'b1;
            default:  w_dec = '0;
        endcase
    end

    assign w_ctrl = cond_pass(instruction[COND_LSB +: 4], statusReg) ? w_dec : '0;

    register_file u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_pc       (pcIn),
        .i_rd_addr1 (w_rn),
        .i_rd_addr2 (w_src2),
        .i_wr_en    (wbEn),
        .i_wr_addr  (wbDest),
        .i_wr_data  (wbValue),
        .o_rd_data1 (w_val_rn),
        .o_rd_data2 (w_val_rm)
    );

    always_comb begin
        w_next               = '0;
        w_next.pc            = pcIn;
        w_next.val_rn        = w_val_rn;
        w_next.val_rm        = w_val_rm;
        w_next.imm           = w_i;
        w_next.shift_operand = instruction[11:0];
        w_next.signed_imm24  = instruction[23:0];
        w_next.dest          = w_rd;
        w_next.ctrl          = w_ctrl;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_idexe <= '0;
        else if (flush)
            r_idexe <= '0;
        else if (freeze)
            r_idexe <= r_idexe;
        else if (hazard)
            r_idexe <= '0;
        else
            r_idexe <= w_next;
    end

    assign pcOut        = r_idexe.pc;
    assign valRn        = r_idexe.val_rn;
    assign valRm        = r_idexe.val_rm;
    assign imm          = r_idexe.imm;
    assign shiftOperand = r_idexe.shift_operand;
    assign signedImm24  = r_idexe.signed_imm24;
    assign dest         = r_idexe.dest;
    assign exeCmd       = r_idexe.ctrl.exe_cmd;
    assign memRead      = r_idexe.ctrl.mem_read;
    assign memWrite     = r_idexe.ctrl.mem_write;
    assign wbEnOut      = r_idexe.ctrl.wb_en;
    assign branch       = r_idexe.ctrl.branch;
    assign statusUpdate = r_idexe.ctrl.status_update;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a per-cycle reference model compared on every
// falling edge, plus directed vectors with hand-computed expectations.
module tb_id_stage;

    logic        clk, rst, flush, freeze;
    logic [31:0] pcIn, instruction;
    logic [3:0]  statusReg;
    logic        wbEn;
    logic [3:0]  wbDest;
    logic [31:0] wbValue;
    logic        exeWbEn, memWbEn;
    logic [3:0]  exeDest, memDest;
    logic        hazard;
    logic [31:0] pcOut, valRn, valRm;
    logic        imm;
    logic [11:0] shiftOperand;
    logic [23:0] signedImm24;
    logic [3:0]  dest, exeCmd;
    logic        memRead, memWrite, wbEnOut, branch, statusUpdate;

    int total = 0;
    int bad   = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .pcIn(pcIn), .instruction(instruction), .statusReg(statusReg),
        .wbEn(wbEn), .wbDest(wbDest), .wbValue(wbValue),
        .exeWbEn(exeWbEn), .exeDest(exeDest), .memWbEn(memWbEn), .memDest(memDest),
        .hazard(hazard), .pcOut(pcOut), .valRn(valRn), .valRm(valRm), .imm(imm),
        .shiftOperand(shiftOperand), .signedImm24(signedImm24), .dest(dest),
        .exeCmd(exeCmd), .memRead(memRead), .memWrite(memWrite), .wbEnOut(wbEnOut),
        .branch(branch), .statusUpdate(statusUpdate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] s24;
        logic [3:0]  dest, cmd;
        logic        mr, mw, wb, br, su;
    } out_t;

    out_t        m_exp;
    bit          m_valid = 0;
    logic [31:0] m_rf [0:14];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ARM conditions come in complementary pairs: the odd code negates the even one.
    function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (c[3:1] == 3'd7) ? !c[0] : (base ^ c[0]);
    endfunction

    function automatic logic [31:0] rf_read(input logic [3:0] a);
        if (a == 4'hF) return pcIn;
        if (wbEn && wbDest == a) return wbValue;
        return m_rf[a];
    endfunction

    function automatic out_t decode_model();
        out_t       o;
        logic [1:0] md;
        logic [3:0] op, src2, cmd;
        bit         l, defined;
        o = '0;
        md = instruction[27:26];
        op = instruction[24:21];
        l  = instruction[20];
        src2 = (md == 2'b01 && !l) ? instruction[15:12] : instruction[3:0];
        o.pc = pcIn;
        o.rn = rf_read(instruction[19:16]);
        o.rm = rf_read(src2);
        o.imm = instruction[25];
        o.sh = instruction[11:0];
        o.s24 = instruction[23:0];
        o.dest = instruction[15:12];
        if (cond_model(instruction[31:28], statusReg)) begin
            if (md == 2'b00) begin
                defined = 1;
                case (op)
                    4'b1101: cmd = 4'b0001;
                    4'b1111: cmd = 4'b1001;
                    4'b0100: cmd = 4'b0010;
                    4'b0101: cmd = 4'b0011;
                    4'b0010, 4'b1010: cmd = 4'b0100;
                    4'b0110: cmd = 4'b0101;
                    4'b0000, 4'b1000: cmd = 4'b0110;
                    4'b1100: cmd = 4'b0111;
                    4'b0001: cmd = 4'b1000;
                    default: begin cmd = 4'b0000; defined = 0; end
                endcase
                if (defined) begin
                    o.cmd = cmd;
                    o.wb  = !(op == 4'b1010 || op == 4'b1000);
                    o.su  = instruction[20];
                end
            end else if (md == 2'b01) begin
                o.cmd = 4'b0010;
                o.mr  = l;
                o.mw  = !l;
                o.wb  = l;
            end else if (md == 2'b10) begin
                o.br = 1;
            end
        end
        return o;
    endfunction

    function automatic bit hazard_model();
        logic [1:0] md;
        logic [3:0] op, rn, src2;
        bit uses1, uses2, is_str;
        md = instruction[27:26];
        op = instruction[24:21];
        rn = instruction[19:16];
        is_str = (md == 2'b01) && !instruction[20];
        src2 = is_str ? instruction[15:12] : instruction[3:0];
        uses1 = (md != 2'b10) && !(md == 2'b00 && (op == 4'b1101 || op == 4'b1111));
        uses2 = (md == 2'b00 && !instruction[25]) || is_str;
        if (flush) return 0;
        return (exeWbEn && ((uses1 && exeDest == rn) || (uses2 && exeDest == src2))) ||
               (memWbEn && ((uses1 && memDest == rn) || (uses2 && memDest == src2)));
    endfunction

    // Inputs change only at posedge+2, so at negedge they are what the next edge samples.
    always @(negedge clk) begin
        out_t act;
        bit   hz;
        act = {pcOut, valRn, valRm, imm, shiftOperand, signedImm24, dest, exeCmd,
               memRead, memWrite, wbEnOut, branch, statusUpdate};
        hz = hazard_model();
        if (m_valid) begin
            chk("model_outputs", act, m_exp);
            chk("model_hazard", hazard, hz);
        end
        if (rst) begin
            m_exp = '0;
            for (int i = 0; i < 15; i++) m_rf[i] = '0;
        end else begin
            if (flush)       m_exp = '0;
            else if (freeze) m_exp = m_exp;
            else if (hz)     m_exp = '0;
            else             m_exp = decode_model();
            if (wbEn && wbDest != 4'hF) m_rf[wbDest] = wbValue;
        end
        m_valid = 1;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        flush = 0; freeze = 0; wbEn = 0; wbDest = 0; wbValue = 0;
        exeWbEn = 0; exeDest = 0; memWbEn = 0; memDest = 0;
        statusReg = 0; pcIn = 0; instruction = 32'hF000_0000;
    endtask

    initial begin
        rst = 1; flush = 1; freeze = 1; pcIn = $urandom; instruction = $urandom;
        statusReg = 4'hA; wbEn = 1; wbDest = 4'd3; wbValue = $urandom;
        exeWbEn = 1; exeDest = 4'd2; memWbEn = 1; memDest = 4'd5;
        cyc(); cyc();
        chk("reset_outputs", {pcOut, valRn, valRm, imm, shiftOperand, signedImm24, dest,
            exeCmd, memRead, memWrite, wbEnOut, branch, statusUpdate}, '0);
        rst = 0;
        idle();
        #1 chk("reset_hazard", hazard, 1'b0);

        for (int i = 0; i < 15; i++) begin
            instruction = 32'hE080_0000 | (i << 16) | i;
            cyc();
            chk("reset_regfile_rn", valRn, 32'h0);
            chk("reset_regfile_rm", valRm, 32'h0);
        end
        pcIn = 32'h100; instruction = 32'hE08F_000F;
        wbEn = 1; wbDest = 4'hF; wbValue = 32'h55;
        cyc();
        chk("r15_reads_pc", valRn, 32'h100);
        chk("r15_pcOut", pcOut, 32'h100);

        idle(); wbEn = 1; wbDest = 4'd2; wbValue = 32'd5; cyc();
        wbDest = 4'd3; wbValue = 32'd7; cyc();
        wbEn = 0; pcIn = 32'h20; instruction = 32'hE082_1003; cyc();
        chk("add_exeCmd", exeCmd, 4'b0010);
        chk("add_valRn", valRn, 32'd5);
        chk("add_valRm", valRm, 32'd7);
        chk("add_dest", dest, 4'd1);
        chk("add_wbEnOut", wbEnOut, 1'b1);

        instruction = 32'h03A0_0001; statusReg = 4'b0000; cyc();
        chk("moveq_fail_controls", {exeCmd, memRead, memWrite, wbEnOut, branch, statusUpdate}, '0);
        statusReg = 4'b0100; cyc();
        chk("moveq_exeCmd", exeCmd, 4'b0001);
        chk("moveq_imm", imm, 1'b1);
        chk("moveq_shift", shiftOperand, 12'h001);
        chk("moveq_wbEnOut", wbEnOut, 1'b1);

        statusReg = 0; instruction = 32'hE082_1003; exeWbEn = 1; exeDest = 4'd2;
        #1 chk("hazard_exe_rn", hazard, 1'b1);
        cyc();
        chk("hazard_bubble", {pcOut, exeCmd, wbEnOut}, '0);
        exeWbEn = 0; instruction = 32'hE585_4008; memWbEn = 1; memDest = 4'd4; pcIn = 32'h30;
        #1 chk("hazard_mem_str_rd", hazard, 1'b1);
        cyc();
        freeze = 1; cyc();
        chk("freeze_over_hazard", exeCmd, 4'b0000);
        freeze = 0; memWbEn = 0;
        #1 chk("hazard_released", hazard, 1'b0);
        cyc();
        chk("str_memWrite", memWrite, 1'b1);
        chk("str_pcOut", pcOut, 32'h30);
        instruction = 32'hE1A0_1002; exeWbEn = 1; exeDest = 4'd0;
        #1 chk("mov_rn_unused", hazard, 1'b0);
        exeDest = 4'd2;
        #1 chk("mov_rm_used", hazard, 1'b1);
        cyc(); exeWbEn = 0;

        instruction = 32'hE082_1003; wbEn = 1; wbDest = 4'd3; wbValue = 32'hDEAD_BEEF; cyc();
        chk("bypass_valRm", valRm, 32'hDEAD_BEEF);
        wbEn = 0; cyc();
        chk("stored_valRm", valRm, 32'hDEAD_BEEF);

        flush = 1; exeWbEn = 1; exeDest = 4'd2; pcIn = 32'h40;
        #1 chk("flush_kills_hazard", hazard, 1'b0);
        cyc();
        chk("flush_bubble", {pcOut, valRn, exeCmd, wbEnOut}, '0);
        flush = 0; exeWbEn = 0; pcIn = 32'h44; cyc();
        freeze = 1; instruction = 32'hE3A0_0009; pcIn = 32'h48;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("freeze_hold_pc", pcOut, 32'h44);
            chk("freeze_hold_cmd", exeCmd, 4'b0010);
        end
        flush = 1; cyc();
        chk("flush_freeze_bubble", {pcOut, exeCmd, wbEnOut}, '0);
        idle();

        for (int op = 0; op < 16; op++) begin
            instruction = 32'hE010_0000 | (op << 21) | (4'd2 << 16) | (4'd6 << 12) | 4'd3;
            cyc();
        end
        instruction = 32'hE152_0003; cyc();
        chk("cmp_ctrl", {exeCmd, wbEnOut, statusUpdate}, {4'b0100, 1'b0, 1'b1});
        instruction = 32'hE072_1003; cyc();
        chk("rsb_undefined", {exeCmd, wbEnOut, statusUpdate}, '0);
        instruction = 32'hE595_4008; cyc();
        chk("ldr_ctrl", {exeCmd, memRead, memWrite, wbEnOut, dest}, {4'b0010, 3'b101, 4'd4});
        instruction = 32'hEA00_0010; cyc();
        chk("branch_ctrl", {branch, signedImm24}, {1'b1, 24'h000010});
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                instruction = {c[3:0], 28'hA00_0004}; statusReg = f[3:0];
                cyc();
            end
        end

        idle(); wbEn = 1; wbDest = 4'd2; wbValue = 32'h77; cyc();
        wbEn = 0; instruction = 32'hE082_1003; exeWbEn = 1; exeDest = 4'd2; rst = 1; cyc();
        rst = 0; exeWbEn = 0; cyc();
        chk("reset_mid_stall_clears_rf", valRn, 32'h0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage ARM pipeline. It sits directly downstream of the instruction-fetch stage, taking `pcIn`/`instruction` from the IF/ID register, and drives the execute stage. The block decodes data-processing, memory and branch instructions, evaluates the condition field, reads and writes the register file, detects RAW hazards against EXE and MEM, and registers its results into an internal ID/EXE pipeline register.

## Interface
Parameters:
- none; all widths are fixed by the ARM encoding.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: branch taken in EXE; the next registered output is a bubble.
- `freeze` in 1: external stall; the ID/EXE register holds its value.
- `pcIn` in 32: PC+4 of the instruction in ID.
- `instruction` in 32: instruction in ID.
- `statusReg` in 4: NZCV as {N,Z,C,V}.
- `wbEn`, `wbDest`, `wbValue` in 1/4/32: register-file write port from WB.
- `exeWbEn`, `exeDest` in 1/4: destination of the instruction in EXE.
- `memWbEn`, `memDest` in 1/4: destination of the instruction in MEM.
- `hazard` out 1: combinational; drives the IF stage `freeze`.
- `pcOut` out 32: registered.
- `valRn`, `valRm` out 32: registered operands.
- `imm` out 1: registered I bit.
- `shiftOperand` out 12: registered.
- `signedImm24` out 24: registered.
- `dest` out 4: registered destination.
- `exeCmd` out 4: registered.
- `memRead`, `memWrite`, `wbEnOut`, `branch`, `statusUpdate` out 1: registered controls.

## Operation
- Fields: `cond[31:28]`, `mode[27:26]` (00 DP, 01 MEM, 10 BR), `I[25]`, `opcode[24:21]`, `S[20]`, `Rn[19:16]`, `Rd[15:12]`, `Rm[3:0]`.
- Opcode to `exeCmd`:
  - MOV→0001, MVN→1001, ADD→0010, ADC→0011.
  - SUB and CMP→0100, SBC→0101, AND and TST→0110.
  - ORR→0111, EOR→1000.
  - MEM→0010.
  - Undefined opcodes produce all controls 0.
- `wbEnOut`:
  - 1 for DP instructions other than CMP and TST.
  - 1 for LDR (MEM with bit20=1).
  - 0 otherwise.
- Other controls:
  - `memRead`=LDR; `memWrite`=STR.
  - `branch`=1 when mode=10.
  - `statusUpdate`=S for DP only.
- Conditions: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL are evaluated per ARM semantics on `statusReg`; 1111 is treated as never. On a condition fail, all controls are forced to 0.
- Sources:
  - `src1`=Rn; it is unused by MOV, MVN and BR.
  - `src2`=Rm for DP with I=0, and Rd for STR.
  - `twoSrc` = (DP & ~I) | STR.
- `hazard` = (exeWbEn & src1 used & exeDest==src1) | (exeWbEn & twoSrc & exeDest==src2), plus the same two terms for MEM. It is forced to 0 while `flush` is 1.
- Register file:
  - R0–R14, with two asynchronous read ports and one synchronous write port.
  - A read of index 15 returns `pcIn`.
  - Write-through: a same-cycle read of `wbDest` returns `wbValue`.
  - A write to index 15 is ignored.
- ID/EXE register update priority, evaluated at each rising edge:
  1. `rst`: all outputs 0 and all registers 0.
  2. `flush`: bubble.
  3. `freeze`: hold.
  4. `hazard`: bubble.
  5. Otherwise: load the decoded values.
- Bubble: all controls and all data fields are 0.

## Timing
- Decode to output: 1 cycle. The instruction present before edge k appears on the outputs after edge k.
- `hazard` is combinational in the same cycle. The IF stage must hold the instruction until `hazard` falls; no instruction is lost.
- Writeback is visible to a same-cycle read through the bypass, and is stored at the edge.
- If `rst` is asserted mid-stall or mid-flush, reset wins and the register file is cleared.
- If `flush` and `hazard` are both 1, the result is a bubble and `hazard` is 0.

## Structure
- Shared package `arm_pkg` holds:
  - Mode encodings and opcode constants.
  - `exeCmd` constants.
  - Condition-code constants.
  - Field bit positions.
- Sub-module `register_file` (15×32) contains the bypass and synchronous reset.
- Decode, condition check and hazard detection are combinational in `id_stage`. The ID/EXE register is an always block in `id_stage`.

## Test plan
1. Reset: hold `rst` for 2 cycles with garbage inputs, then 0 → every output is 0, `hazard`=0, and reading R0–R14 returns 0.
2. ADD: write R2=5 and R3=7 via WB, then present 0xE0821003 → after 1 edge, `exeCmd`=0010, `valRn`=5, `valRm`=7, `dest`=1, `wbEnOut`=1.
3. Condition:
   - 0x03A00001 (MOVEQ R0,#1) with Z=0 → bubble.
   - Same instruction with Z=1 → `exeCmd`=0001, `imm`=1, `shiftOperand`=0x001, `wbEnOut`=1.
4. Hazard:
   - 0xE0821003 with `exeWbEn`=1 and `exeDest`=2 → `hazard`=1 and the output is a bubble.
   - STR 0xE5854008 with `memWbEn`=1 and `memDest`=4 → `hazard`=1.
   - Release the hazard → decoded values load on the next edge.
5. Bypass: `wbEn`=1, `wbDest`=3, `wbValue`=0xDEADBEEF in the same cycle as 0xE0821003 → `valRm`=0xDEADBEEF.
6. Flush/freeze:
   - `flush`=1 with a valid ADD → bubble.
   - `freeze`=1 for 3 cycles → outputs unchanged.
   - `flush`+`freeze` together → bubble.
